// File: rtl/cstn_line_packer.sv
// cstn_line_packer: packs dithered subpixel bits into BUS_W-bit CSTN words and generates CP/LP/FLM timing.
// Define CSTN_PACKER_M_OUT_EN to add the lcd_m frame-rate AC-drive polarity output. BUS_W must be at least 2.
module cstn_line_packer #(
  parameter int BUS_W    = 8,
  parameter int H_SUBPIX = 1920,
  parameter int V_LINES  = 480,
  parameter int LP_W     = 2,
  parameter int H_BLANK  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_bit,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             inv,
  output logic             sof,
  output logic [BUS_W-1:0] lcd_d,
  output logic             lcd_cp,
  output logic             lcd_lp,
  output logic             lcd_flm
`ifdef CSTN_PACKER_M_OUT_EN
  ,
  output logic             lcd_m
`endif
);
  localparam int WORDS = H_SUBPIX / BUS_W;
  localparam int BW = BUS_W > 1 ? $clog2(BUS_W) : 1;
  localparam int WW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int LW = V_LINES > 1 ? $clog2(V_LINES) : 1;
  localparam int PW = LP_W > 1 ? $clog2(LP_W) : 1;
  localparam int HW = H_BLANK > 1 ? $clog2(H_BLANK) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(BUS_W - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(WORDS - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(V_LINES - 1);
  localparam logic [PW-1:0] LP_LAST = PW'(LP_W - 1);
  localparam logic [HW-1:0] HB_LAST = HW'(H_BLANK > 0 ? H_BLANK - 1 : 0);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACTIVE = 3'd1;
  localparam logic [2:0] S_CPLAST = 3'd2;
  localparam logic [2:0] S_LPULSE = 3'd3;
  localparam logic [2:0] S_HBLANK = 3'd4;
  logic [2:0] state;
  logic [BW-1:0] bit_cnt;
  logic [WW-1:0] word_cnt;
  logic [LW-1:0] line_cnt;
  logic [PW-1:0] lp_cnt;
  logic [HW-1:0] hb_cnt;
  logic [BUS_W-2:0] sr;
  logic [BUS_W-1:0] word;
  logic phase, fresh, cp_q;
  // phase tracks subpixel_index[0] so inv never needs the full index
  assign word = {sr, pix_bit};
  assign pix_ready = state == S_ACTIVE;
  assign lcd_lp = state == S_LPULSE;
  assign lcd_flm = lcd_lp && line_cnt == LINE_LAST;
  assign sof = pix_ready && fresh && line_cnt == '0;
  assign inv = pix_ready && (phase ^ line_cnt[0]);
  assign lcd_cp = cp_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      bit_cnt <= '0;
      word_cnt <= '0;
      line_cnt <= '0;
      lp_cnt <= '0;
      hb_cnt <= '0;
      sr <= '0;
      lcd_d <= '0;
      phase <= 1'b0;
      fresh <= 1'b0;
      cp_q <= 1'b0;
`ifdef CSTN_PACKER_M_OUT_EN
      lcd_m <= 1'b0;
`endif
    end else begin
      cp_q <= 1'b0;
      case (state)
        S_IDLE: begin
          state <= S_ACTIVE;
          fresh <= 1'b1;
        end
        S_ACTIVE: begin
          fresh <= 1'b0;
          if (pix_valid) begin
            phase <= ~phase;
            sr <= word[BUS_W-2:0];
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              lcd_d <= word;
              cp_q <= 1'b1;
              if (word_cnt == WORD_LAST) begin
                word_cnt <= '0;
                phase <= 1'b0;
                state <= S_CPLAST;
              end else
                word_cnt <= word_cnt + 1'b1;
            end else
              bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_CPLAST: begin
          lp_cnt <= '0;
          state <= S_LPULSE;
        end
        S_LPULSE: begin
          if (lp_cnt == LP_LAST) begin
            line_cnt <= line_cnt == LINE_LAST ? '0 : line_cnt + 1'b1;
`ifdef CSTN_PACKER_M_OUT_EN
            if (lcd_flm) lcd_m <= ~lcd_m;
`endif
            hb_cnt <= '0;
            state <= H_BLANK == 0 ? S_ACTIVE : S_HBLANK;
            fresh <= H_BLANK == 0;
          end else
            lp_cnt <= lp_cnt + 1'b1;
        end
        S_HBLANK: begin
          if (hb_cnt == HB_LAST) begin
            state <= S_ACTIVE;
            fresh <= 1'b1;
          end else
            hb_cnt <= hb_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cstn_line_packer.sv
// tb_cstn_line_packer: scoreboarded bench for cstn_line_packer with BUS_W=4, H_SUBPIX=8, V_LINES=3, LP_W=2, H_BLANK=3.
module tb_cstn_line_packer;
  localparam int V = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pix_bit = 1'b0;
  logic pix_valid = 1'b0;
  logic pix_ready, inv, sof, lcd_cp, lcd_lp, lcd_flm;
  logic [3:0] lcd_d;
`ifdef CSTN_PACKER_M_OUT_EN
  logic lcd_m;
  logic exp_m = 1'b0;
`endif
  int checks = 0;
  int errors = 0;
  logic [3:0] q[$];

  cstn_line_packer #(.BUS_W(4), .H_SUBPIX(8), .V_LINES(3), .LP_W(2), .H_BLANK(3)) dut (
    .clk(clk), .rst(rst), .pix_bit(pix_bit), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .inv(inv), .sof(sof), .lcd_d(lcd_d), .lcd_cp(lcd_cp), .lcd_lp(lcd_lp), .lcd_flm(lcd_flm)
`ifdef CSTN_PACKER_M_OUT_EN
    , .lcd_m(lcd_m)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: every CP pulse must present the next queued word
  always @(negedge clk) begin
    if (!rst && lcd_cp) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cp_unexpected: lcd_d=%h with no word expected at %0t", lcd_d, $time);
      end else
        chk("lcd_d", 32'(lcd_d), 32'(q.pop_front()));
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_d"}, 32'(lcd_d), 0);
    chk({nm, "_cp"}, 32'(lcd_cp), 0);
    chk({nm, "_lp"}, 32'(lcd_lp), 0);
    chk({nm, "_flm"}, 32'(lcd_flm), 0);
    chk({nm, "_ready"}, 32'(pix_ready), 0);
    chk({nm, "_sof"}, 32'(sof), 0);
    chk({nm, "_inv"}, 32'(inv), 0);
`ifdef CSTN_PACKER_M_OUT_EN
    chk({nm, "_m"}, 32'(lcd_m), 0);
`endif
  endtask

  task automatic send_line(input logic [7:0] bits, input int ln, input int stall_at);
    q.push_back(bits[7:4]);
    q.push_back(bits[3:0]);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at)
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          pix_valid = 1'b0;
          chk("stall_ready", 32'(pix_ready), 1);
          chk("stall_cp", 32'(lcd_cp), 0);
          chk("stall_inv", 32'(inv), 32'((i % 2) ^ (ln % 2)));
        end
      @(negedge clk);
      chk("ready", 32'(pix_ready), 1);
      chk("inv", 32'(inv), 32'((i % 2) ^ (ln % 2)));
      chk("sof", 32'(sof), 32'(i == 0 && ln == 0));
      chk("cp", 32'(lcd_cp), 32'(i == 4 && stall_at != 4));
      pix_valid = 1'b1;
      pix_bit = bits[7-i];
    end
    @(negedge clk);
    pix_valid = 1'b0;
    chk("cplast_cp", 32'(lcd_cp), 1);
    chk("cplast_ready", 32'(pix_ready), 0);
    chk("cplast_lp", 32'(lcd_lp), 0);
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      chk("lp", 32'(lcd_lp), 1);
      chk("lp_flm", 32'(lcd_flm), 32'(ln == V - 1));
      chk("lp_ready", 32'(pix_ready), 0);
      chk("lp_cp", 32'(lcd_cp), 0);
    end
`ifdef CSTN_PACKER_M_OUT_EN
    if (ln == V - 1) exp_m = ~exp_m;
`endif
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      chk("hb_lp", 32'(lcd_lp), 0);
      chk("hb_ready", 32'(pix_ready), 0);
      chk("hb_flm", 32'(lcd_flm), 0);
      chk("hb_inv", 32'(inv), 0);
`ifdef CSTN_PACKER_M_OUT_EN
      chk("lcd_m", 32'(lcd_m), 32'(exp_m));
`endif
    end
  endtask

  initial begin
    logic [7:0] pat;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(pix_ready), 0);
    chk("idle_sof", 32'(sof), 0);
    send_line(8'b10110010, 0, -1);
    send_line(8'b11001010, 1, 2);
    send_line(8'b01101001, 2, -1);
    send_line(8'b11110000, 0, -1);
    send_line(8'b00011110, 1, -1);
    send_line(8'b10011001, 2, -1);
    pat = 8'b01101100;
    q.push_back(pat[7:4]);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pix_valid = 1'b1;
      pix_bit = pat[7-i];
    end
    @(negedge clk);
    pix_valid = 1'b0;
    chk("pre_rst_d", 32'(lcd_d), 32'h6);
    #2 rst = 1'b1;
    #1 chk_zero("midrst");
`ifdef CSTN_PACKER_M_OUT_EN
    exp_m = 1'b0;
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle2_ready", 32'(pix_ready), 0);
    send_line(8'b00111100, 0, -1);
    send_line(8'b10100101, 1, -1);
    send_line(8'b01011010, 2, -1);
    chk("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
